mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single memory request port between three masters: reprogram writer (rpg), DMA engine (dma) and CPU (cpu).
- Sits between the masters and the memory block, in front of its CPU-side port.
- rpg has fixed top priority, bounded by a burst limit; cpu and dma share the remaining bandwidth round-robin.
- One transaction is outstanding at a time; every request is held until its ok pulse.

Parameters:
- RPG_BURST, 8: max consecutive rpg grants while cpu/dma are pending; range 1..255.
- TIMEOUT, 255: BUSY cycles without m_ok before abort. Used only with ARB_TIMEOUT_EN; range 1..65535.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- rpg_addr/dma_addr/cpu_addr  in  32 each  request address.
- rpg_wdata/dma_wdata/cpu_wdata  in  32 each  write data.
- rpg_width/dma_width/cpu_width  in  2 each  access width code, passed through unchanged.
- rpg_read/dma_read/cpu_read  in  1 each  read request.
- rpg_write/dma_write/cpu_write  in  1 each  write request.
- rpg_ok/dma_ok/cpu_ok  out  1 each  one-cycle completion pulse.
- rdata  out  32  read data, valid while any *_ok is high.
- m_addr  out  32  to memory.
- m_wdata  out  32  to memory.
- m_width  out  2  to memory.
- m_read  out  1  to memory.
- m_write  out  1  to memory.
- m_ok  in  1  memory completion.
- m_rdata  in  32  memory read data.
- err  out  1  sticky timeout flag.

Behaviour:
- Interface decided: one clock clk; reset rstn is asynchronous, active-low.
- Request = read|write. A master holds addr/wdata/width/read/write stable until it samples its ok. It may change or drop the request at the same edge. read and write both high is treated as write.
- All outputs are registered. Reset values:
  - m_*, *_ok, rdata, err all 0.
  - state IDLE.
  - rr pointer points to cpu.
  - burst counter 0.
- States: IDLE, BUSY, DONE.
- IDLE, no request: stay; m_read = m_write = 0.
- IDLE, any request: choose a winner and go to BUSY. In the same edge, latch the winner's addr/wdata/width/read/write into m_*. m_read/m_write are high from the first BUSY cycle (1-cycle grant latency).
- Winner selection:
  - rpg wins if it requests, unless burst counter == RPG_BURST and cpu or dma is requesting.
  - Otherwise cpu vs dma by rr pointer: the pointed master wins if it requests, else the other.
  - After a cpu or dma grant, rr points to the other of the two.
- Burst counter:
  - +1 on each rpg grant, saturating at RPG_BURST.
  - Cleared on any cpu or dma grant.
  - Cleared when rpg is granted and neither cpu nor dma is requesting.
- BUSY: hold m_* stable. On m_ok sampled high:
  - rdata <= m_rdata.
  - Winner's ok <= 1.
  - m_read/m_write <= 0.
  - Go to DONE.
- DONE: exactly one cycle with the winner's ok high, then IDLE. No grant is made in DONE, which guarantees the finished request is never serviced twice.
- Minimum request-to-ok latency: 2 cycles (m_ok high in the first BUSY cycle).
- Requests changing during BUSY are ignored until IDLE.
- A dropped request during BUSY is protocol misuse; the transaction still completes.
- rdata holds its last value outside DONE; it is updated on writes too, and the value is don't-care for writes.
- Reset asserted mid-transaction: immediate return to reset values. The aborted master never sees ok and must reissue.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entering BUSY, incremented every BUSY cycle.
  - When it reaches TIMEOUT without m_ok: go to DONE with the winner's ok pulsed, rdata = 32'hDEADBEEF, m_read/m_write dropped, err set.
  - err stays set until reset.
- Undefined: no counter; BUSY waits for m_ok indefinitely; err tied to 0.

Test Plan:
- Reset: rstn low mid-BUSY -> all m_*, *_ok, err go 0 asynchronously. After release, cpu read at 0x0300_0000 -> m_read high 1 cycle later.
- Single cpu read 0x0200_0010, width 2'b10, m_ok after 3 cycles with m_rdata 0x1234_5678 -> cpu_ok high exactly 1 cycle, rdata = 0x1234_5678, m_read low in DONE.
- cpu and dma both hold requests continuously for 4 transactions -> grant order cpu, dma, cpu, dma.
- rpg write stream plus cpu request pending, RPG_BURST = 8 -> 8 rpg grants, then 1 cpu grant, then rpg resumes. m_wdata equals the granted master's wdata each time.
- dma write 0x0600_0000 data 0xA5A5_5A5A while rpg idle -> m_write high, m_addr/m_wdata match. No second transaction in the cycle after dma_ok while dma drops its request.
- ARB_TIMEOUT_EN, TIMEOUT = 4, m_ok held low -> cpu_ok after 4 BUSY cycles, rdata = 0xDEADBEEF, err = 1 and stays 1. Without the macro -> no ok, err = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request port between the reprogram writer
// (rpg), the DMA engine (dma) and the CPU (cpu). rpg has top priority, capped
// at RPG_BURST consecutive grants while cpu/dma wait; cpu and dma alternate.
// One transaction is in flight at a time and every output is registered.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT cycles without m_ok (ok pulsed, rdata = 32'hDEADBEEF, sticky err).
//
// state | meaning
// IDLE  | waiting for any request; picks the winner and latches its command
// BUSY  | command presented on m_*; waiting for m_ok (or the watchdog)
// DONE  | winner's ok high for this single cycle; no new grant here
module mem_arbiter #(
  parameter int RPG_BURST = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] rpg_addr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] rpg_wdata,
  input  logic [31:0] dma_wdata,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  rpg_width,
  input  logic [1:0]  dma_width,
  input  logic [1:0]  cpu_width,
  input  logic        rpg_read,
  input  logic        dma_read,
  input  logic        cpu_read,
  input  logic        rpg_write,
  input  logic        dma_write,
  input  logic        cpu_write,
  output logic        rpg_ok,
  output logic        dma_ok,
  output logic        cpu_ok,
  output logic [31:0] rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_width,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_ok,
  input  logic [31:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] BURST_MAX = 8'(RPG_BURST);

  state_t      state_q;
  logic [31:0] m_addr_q, m_wdata_q, rdata_q;
  logic [1:0]  m_width_q;
  logic        m_read_q, m_write_q;
  logic [2:0]  ok_q;      // {cpu, dma, rpg}
  logic [2:0]  owner_q;   // one-hot winner of the transaction in flight
  logic        rr_dma_q;  // 0: cpu is preferred next, 1: dma is preferred next
  logic [7:0]  burst_q, burst_d;

  logic        req_rpg, req_dma, req_cpu, shared_req;
  logic        grant_rpg, grant_dma, grant_cpu;
  logic [31:0] sel_addr_d, sel_wdata_d;
  logic [1:0]  sel_width_d;
  logic        sel_read_d, sel_write_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q;     // completed BUSY cycles of the current transaction
  logic        err_q;
`endif

  // Winner selection, command mux and next burst count for an IDLE grant
  always_comb begin
    req_rpg    = rpg_read | rpg_write;
    req_dma    = dma_read | dma_write;
    req_cpu    = cpu_read | cpu_write;
    shared_req = req_cpu | req_dma;

    grant_rpg = req_rpg && !(burst_q == BURST_MAX && shared_req);
    grant_cpu = !grant_rpg && req_cpu && (!rr_dma_q || !req_dma);
    grant_dma = !grant_rpg && !grant_cpu && req_dma;

    sel_addr_d  = rpg_addr;
    sel_wdata_d = rpg_wdata;
    sel_width_d = rpg_width;
    sel_read_d  = rpg_read;
    sel_write_d = rpg_write;
    if (grant_dma) begin
      sel_addr_d  = dma_addr;
      sel_wdata_d = dma_wdata;
      sel_width_d = dma_width;
      sel_read_d  = dma_read;
      sel_write_d = dma_write;
    end else if (grant_cpu) begin
      sel_addr_d  = cpu_addr;
      sel_wdata_d = cpu_wdata;
      sel_width_d = cpu_width;
      sel_read_d  = cpu_read;
      sel_write_d = cpu_write;
    end

    // Only rpg grants made while others wait count towards the burst cap
    burst_d = burst_q;
    if (grant_rpg) begin
      if (!shared_req)
        burst_d = 8'd0;
      else if (burst_q != BURST_MAX)
        burst_d = burst_q + 8'd1;
    end else if (grant_cpu || grant_dma) begin
      burst_d = 8'd0;
    end
  end

  // Arbitration FSM with registered memory command, ok pulses and read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_width_q <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      rdata_q   <= '0;
      ok_q      <= '0;
      owner_q   <= '0;
      rr_dma_q  <= 1'b0;
      burst_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rpg || shared_req) begin
            m_addr_q  <= sel_addr_d;
            m_wdata_q <= sel_wdata_d;
            m_width_q <= sel_width_d;
            m_write_q <= sel_write_d;
            m_read_q  <= sel_read_d & ~sel_write_d;  // read+write means write
            owner_q   <= {grant_cpu, grant_dma, grant_rpg};
            burst_q   <= burst_d;
            if (grant_cpu)
              rr_dma_q <= 1'b1;
            else if (grant_dma)
              rr_dma_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (m_ok) begin
            rdata_q   <= m_rdata;
            ok_q      <= owner_q;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= DONE;
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            rdata_q   <= 32'hDEAD_BEEF;
            ok_q      <= owner_q;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
`endif
          end
        end
        DONE: begin
          ok_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_width = m_width_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign rdata   = rdata_q;
  assign rpg_ok  = ok_q[0];
  assign dma_ok  = ok_q[1];
  assign cpu_ok  = ok_q[2];
`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
